// File: rtl/ifetch.sv
// Instruction-fetch stage with IF/ID register, a one-entry skid buffer for words that
// return while decode is stalled, and delayed-branch redirect handling.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [2:0]  npc_op,
    input  logic        br_cond,
    input  logic [31:0] imm,
    input  logic [31:0] jr_addr,
    output logic [31:0] inst_id,
    output logic [31:0] pc_id,
    output logic        id_valid
);

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic [31:0] inst_id_q, inst_id_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        pend_q, pend_d;
    logic [31:0] tgt_q, tgt_d;

    logic        id_free;
    logic        redir;
    logic [31:0] pc_id_plus4;
    logic [31:0] tgt_raw;
    logic [31:0] target;
    logic [31:0] next_pc;

    always_comb begin
        id_free     = !id_valid_q || !stall;
        pc_id_plus4 = pc_id_q + 32'd4;

        redir = 1'b0;
        unique case (npc_op)
            3'b010: begin
                tgt_raw = pc_id_plus4 + (imm << 2);
                redir   = br_cond;
            end
            3'b011: begin
                tgt_raw = {pc_id_plus4[31:28], inst_id_q[25:0], 2'b00};
                redir   = 1'b1;
            end
            3'b100: begin
                tgt_raw = jr_addr;
                redir   = 1'b1;
            end
            default: tgt_raw = pc_id_plus4;
        endcase
        redir  = redir && id_valid_q && !stall;
        target = {tgt_raw[31:2], 2'b00};

        // The word returning now is the delay slot when a redirect is pending or firing.
        if (redir) begin
            next_pc = target;
        end else if (pend_q) begin
            next_pc = tgt_q;
        end else begin
            next_pc = pc_f_q + 32'd4;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_f_d      = pc_f_q;
        pc_id_d     = pc_id_q;
        inst_id_d   = inst_id_q;
        id_valid_d  = id_valid_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        pend_d      = pend_q;
        tgt_d       = tgt_q;

        unique case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (imem_rvalid) begin
                    pc_f_d = next_pc;
                    pend_d = 1'b0;
                    if (id_free) begin
                        inst_id_d  = imem_rdata;
                        pc_id_d    = pc_f_q;
                        id_valid_d = 1'b1;
                    end else begin
                        skid_inst_d = imem_rdata;
                        skid_pc_d   = pc_f_q;
                        state_d     = StHold;
                    end
                end else begin
                    if (redir) begin
                        pend_d = 1'b1;
                        tgt_d  = target;
                    end
                    if (id_valid_q && !stall) begin
                        id_valid_d = 1'b0;
                        inst_id_d  = 32'h0;
                    end
                end
            end
            StHold: begin
                if (!stall) begin
                    inst_id_d  = skid_inst_q;
                    pc_id_d    = skid_pc_q;
                    id_valid_d = 1'b1;
                    state_d    = StFetch;
                    if (redir) begin
                        pc_f_d = target;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_f_q      <= RESET_PC;
            pc_id_q     <= RESET_PC;
            inst_id_q   <= 32'h0;
            id_valid_q  <= 1'b0;
            skid_inst_q <= 32'h0;
            skid_pc_q   <= RESET_PC;
            pend_q      <= 1'b0;
            tgt_q       <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_f_q      <= pc_f_d;
            pc_id_q     <= pc_id_d;
            inst_id_q   <= inst_id_d;
            id_valid_q  <= id_valid_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
            pend_q      <= pend_d;
            tgt_q       <= tgt_d;
        end
    end

    assign imem_req  = (state_q == StFetch);
    assign imem_addr = pc_f_q;
    assign inst_id   = inst_id_q;
    assign pc_id     = pc_id_q;
    assign id_valid  = id_valid_q;

endmodule
